// File: rtl/dog_motion_sequencer_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : dog_motion_sequencer_if                                 |
// | Description : Control inputs and movement-code outputs of the dog toy |
// |               motion sequencer, bundled for the driver and sequencer. |
// | Revision    : 1.0 - initial release                                   |
// +----------------------------------------------------------------------+
interface dog_motion_sequencer_if;
  logic start;
  logic stop;
  logic obstacle;
  logic bit0;
  logic bit1;
  logic bit2;
  logic busy;

  modport master (
    output start,
    output stop,
    output obstacle,
    input  bit0,
    input  bit1,
    input  bit2,
    input  busy
  );

  modport slave (
    input  start,
    input  stop,
    input  obstacle,
    output bit0,
    output bit1,
    output bit2,
    output busy
  );
endinterface
`default_nettype wire

// File: rtl/dog_motion_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : dog_motion_sequencer                                    |
// | Description : Timed six-step patrol routine producing the 3-bit       |
// |               movement code; OBSTACLE_AVOID_EN adds back-off/turn.    |
// | Revision    : 1.0 - initial release                                   |
// +----------------------------------------------------------------------+
module dog_motion_sequencer #(
  parameter logic [31:0] STEP_CYCLES  = 32'd50_000_000,
  parameter logic [31:0] AVOID_CYCLES = 32'd25_000_000
) (
  input  wire                           clk,
  input  wire                           rst,
  dog_motion_sequencer_if.slave         mot
);

`ifdef OBSTACLE_AVOID_EN
  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_PATROL     = 2'd1,
    ST_AVOID_BACK = 2'd2,
    ST_AVOID_TURN = 2'd3
  } state_t;
  localparam logic [31:0] c_avoid_load = AVOID_CYCLES - 32'd1;
`else
  typedef enum logic [0:0] {
    ST_IDLE   = 1'd0,
    ST_PATROL = 1'd1
  } state_t;
`endif

  localparam logic [31:0] c_step_load  = STEP_CYCLES - 32'd1;

  localparam logic [2:0] c_code_stop    = 3'b000;
  localparam logic [2:0] c_code_forward = 3'b001;
  localparam logic [2:0] c_code_left    = 3'b010;
  localparam logic [2:0] c_code_right   = 3'b011;
  localparam logic [2:0] c_code_back    = 3'b100;
  localparam logic [2:0] c_code_sit     = 3'b101;
  localparam logic [2:0] c_code_wag     = 3'b110;

  localparam logic [2:0] c_last_index   = 3'd5;

  state_t      r_state;
  logic [2:0]  r_index;
  logic [31:0] r_count;
  logic        r_start_prev;
  logic [2:0]  r_code;
  logic        r_busy;

  state_t      w_state_next;
  logic [2:0]  w_index_next;
  logic [31:0] w_count_next;
  logic [2:0]  w_code_next;
  logic        w_start_edge;
  logic        w_expired;
  logic [2:0]  w_index_adv;

  assign w_start_edge = mot.start & ~r_start_prev;
  assign w_expired    = (r_count == 32'd0);
  assign w_index_adv  = (r_index == c_last_index) ? 3'd0 : r_index + 3'd1;

`ifndef OBSTACLE_AVOID_EN
  logic w_unused_ok;
  assign w_unused_ok = ^{mot.obstacle, AVOID_CYCLES};
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_index      <= 3'd0;
      r_count      <= 32'd0;
      r_start_prev <= 1'b1;
      r_code       <= c_code_stop;
      r_busy       <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_index      <= w_index_next;
      r_count      <= w_count_next;
      r_start_prev <= mot.start;
      r_code       <= w_code_next;
      r_busy       <= (w_code_next != c_code_stop);
    end
  end

  // During avoidance r_index already holds the step to resume at.
  always_comb begin
    w_state_next = r_state;
    w_index_next = r_index;
    w_count_next = w_expired ? 32'd0 : r_count - 32'd1;

    if (mot.stop) begin
      w_state_next = ST_IDLE;
      w_index_next = 3'd0;
      w_count_next = 32'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          w_count_next = 32'd0;
          if (w_start_edge) begin
            w_state_next = ST_PATROL;
            w_index_next = 3'd0;
            w_count_next = c_step_load;
          end
        end
        ST_PATROL: begin
`ifdef OBSTACLE_AVOID_EN
          if (mot.obstacle && (r_index == 3'd0 || r_index == 3'd2)) begin
            w_state_next = ST_AVOID_BACK;
            w_index_next = r_index + 3'd1;
            w_count_next = c_avoid_load;
          end else
`endif
          if (w_expired) begin
            w_index_next = w_index_adv;
            w_count_next = c_step_load;
          end
        end
`ifdef OBSTACLE_AVOID_EN
        ST_AVOID_BACK: begin
          if (w_expired) begin
            w_state_next = ST_AVOID_TURN;
            w_count_next = c_avoid_load;
          end
        end
        ST_AVOID_TURN: begin
          if (w_expired) begin
            w_state_next = ST_PATROL;
            w_count_next = c_step_load;
          end
        end
`endif
        default: begin
          w_state_next = ST_IDLE;
          w_index_next = 3'd0;
          w_count_next = 32'd0;
        end
      endcase
    end
  end

  // The registered code is decoded from the next state so it tracks it with no lag.
  always_comb begin
    w_code_next = c_code_stop;
    case (w_state_next)
      ST_PATROL: begin
        case (w_index_next)
          3'd0:    w_code_next = c_code_forward;
          3'd1:    w_code_next = c_code_left;
          3'd2:    w_code_next = c_code_forward;
          3'd3:    w_code_next = c_code_right;
          3'd4:    w_code_next = c_code_sit;
          3'd5:    w_code_next = c_code_wag;
          default: w_code_next = c_code_stop;
        endcase
      end
`ifdef OBSTACLE_AVOID_EN
      ST_AVOID_BACK: w_code_next = c_code_back;
      ST_AVOID_TURN: w_code_next = c_code_right;
`endif
      default: w_code_next = c_code_stop;
    endcase
  end

  assign mot.bit0 = r_code[2];
  assign mot.bit1 = r_code[1];
  assign mot.bit2 = r_code[0];
  assign mot.busy = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_dog_motion_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_dog_motion_sequencer                                 |
// | Description : Directed bench for dog_motion_sequencer, STEP=4 AVOID=2.|
// | Revision    : 1.0 - initial release                                   |
// +----------------------------------------------------------------------+
module tb_dog_motion_sequencer;
  logic clk;
  logic rst;
  int   n_checks;
  int   n_pass;

  dog_motion_sequencer_if mot ();

  dog_motion_sequencer #(
    .STEP_CYCLES  (32'd4),
    .AVOID_CYCLES (32'd2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .mot (mot.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [2:0] exp_code);
    logic [2:0] code;
    logic       exp_busy;
    code     = {mot.bit0, mot.bit1, mot.bit2};
    exp_busy = (exp_code != 3'b000);
    n_checks++;
    assert ({code, mot.busy} === {exp_code, exp_busy}) n_pass++;
    else $error("FAIL %s: code=%b busy=%b, expected code=%b busy=%b",
                tag, code, mot.busy, exp_code, exp_busy);
  endtask

  logic [2:0] patrol [0:5];

  initial begin
    patrol[0] = 3'b001; patrol[1] = 3'b010; patrol[2] = 3'b001;
    patrol[3] = 3'b011; patrol[4] = 3'b101; patrol[5] = 3'b110;
    n_checks = 0;
    n_pass   = 0;
    mot.start    = 1'b1;
    mot.stop     = 1'b0;
    mot.obstacle = 1'b0;
    rst          = 1'b1;

    // Reset with start held high must not launch the patrol.
    tick(); tick();
    chk("reset", 3'b000);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("start_held_after_reset", 3'b000);
    end
    mot.start = 1'b0;
    tick();
    chk("idle", 3'b000);

    // Full patrol, then wrap back to FORWARD.
    mot.start = 1'b1;
    for (int s = 0; s < 6; s++) begin
      for (int c = 0; c < 4; c++) begin
        tick();
        mot.start = 1'b0;
        chk($sformatf("patrol_s%0d_c%0d", s, c), patrol[s]);
      end
    end
    for (int c = 0; c < 4; c++) begin
      tick();
      chk("wrap_forward", 3'b001);
    end
    tick();
    chk("wrap_left_c0", 3'b010);
    tick();
    chk("wrap_left_c1", 3'b010);

    // Stop in the 2nd cycle of LEFT.
    mot.stop = 1'b1;
    tick();
    chk("stop_mid_left", 3'b000);
    mot.stop = 1'b0;

    // Stop beats a simultaneous start edge.
    mot.start = 1'b1;
    mot.stop  = 1'b1;
    tick();
    chk("stop_and_start", 3'b000);
    mot.stop  = 1'b0;
    mot.start = 1'b0;
    tick();
    chk("idle_after_stop", 3'b000);

    // Restart; start stays high so no further edge occurs.
    mot.start = 1'b1;
    tick();
    chk("restart_c0", 3'b001);
    tick();
    chk("restart_c1", 3'b001);
    tick();
    chk("restart_c2", 3'b001);

    // Obstacle in the 3rd cycle of the first FORWARD, held through LEFT.
    mot.obstacle = 1'b1;
`ifdef OBSTACLE_AVOID_EN
    tick(); chk("avoid_back_c0", 3'b100);
    tick(); chk("avoid_back_c1", 3'b100);
    tick(); chk("avoid_turn_c0", 3'b011);
    tick(); chk("avoid_turn_c1", 3'b011);
`else
    tick(); chk("obstacle_ignored_fwd", 3'b001);
`endif
    for (int c = 0; c < 4; c++) begin
      tick();
      chk($sformatf("left_after_obstacle_c%0d", c), 3'b010);
    end
    mot.obstacle = 1'b0;
    tick();
    chk("forward_index2", 3'b001);

    // Reset during back-off (or mid-patrol without avoidance).
    mot.obstacle = 1'b1;
    tick();
`ifdef OBSTACLE_AVOID_EN
    chk("back_before_reset", 3'b100);
`else
    chk("forward_before_reset", 3'b001);
`endif
    mot.obstacle = 1'b0;
    rst = 1'b1;
    tick();
    chk("mid_run_reset", 3'b000);
    rst = 1'b0;
    mot.start = 1'b0;
    tick();
    chk("idle_after_reset", 3'b000);
    mot.start = 1'b1;
    tick();
    chk("start_after_reset", 3'b001);
    mot.start = 1'b0;
    tick();
    chk("start_after_reset_c1", 3'b001);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
`default_nettype wire
